// File: rtl/framed_serializer.sv
// framed_serializer: valid/ready word in, framed serial stream out (start, data, optional even parity, stop)
module framed_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  parity;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         idx;
    logic                  bit_end;
    logic                  accept;
    logic                  head;

    assign bit_end  = bit_cnt == BC_LAST;
    assign in_ready = !reset && (state == IDLE || (state == STOP && bit_end));
    assign accept   = in_valid && in_ready;
    assign head     = LSB_FIRST != 0 ? shreg[0] : shreg[DATA_WIDTH-1];
    assign shifted  = LSB_FIRST != 0 ? shreg >> 1 : shreg << 1;

    // Frame sequencer: each state holds its bit for BIT_CYCLES cycles; outputs are registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            parity     <= 1'b0;
            bit_cnt    <= '0;
            idx        <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            bit_cnt    <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                START: if (bit_end) begin
                    state      <= DATA;
                    idx        <= '0;
                    serial_out <= head;
                    shreg      <= shifted;
                end
                DATA: if (bit_end) begin
                    if (idx != IDX_LAST) begin
                        idx        <= idx + 1'b1;
                        serial_out <= head;
                        shreg      <= shifted;
                    end else if (PARITY_EN != 0) begin
                        state      <= PARITY;
                        serial_out <= parity;
                    end else begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end
                end
                PARITY: if (bit_end) begin
                    state      <= STOP;
                    serial_out <= 1'b1;
                end
                STOP: if (bit_end) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // acceptance (from IDLE or the last STOP cycle) overrides the end-of-frame return to IDLE
            if (accept) begin
                state      <= START;
                shreg      <= in_data;
                parity     <= ^in_data;
                serial_out <= 1'b0;
                busy       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_framed_serializer.sv
// tb_framed_serializer: scoreboard bench over four parameter sets of framed_serializer
module tb_framed_serializer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] dat [4];
    logic        vld [4];
    logic        rdy [4];
    logic        so  [4];
    logic        bz  [4];
    logic        fd  [4];

    int dw  [4] = '{8, 8, 5, 32};
    int lsb [4] = '{1, 0, 1, 0};
    int pen [4] = '{1, 1, 0, 1};
    int bc  [4] = '{1, 4, 1, 2};
    logic [31:0] dir [4] = '{32'h41, 32'h07, 32'h1F, 32'hDEADBEEF};

    logic [1:0] q [4][$];
    bit pend [4];
    int acc [4];
    int tests = 0;
    int fails = 0;

    framed_serializer u0 (
        .clock(clock), .reset(reset), .in_data(dat[0][7:0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .serial_out(so[0]), .busy(bz[0]), .frame_done(fd[0]));
    framed_serializer #(.LSB_FIRST(0), .BIT_CYCLES(4)) u1 (
        .clock(clock), .reset(reset), .in_data(dat[1][7:0]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .serial_out(so[1]), .busy(bz[1]), .frame_done(fd[1]));
    framed_serializer #(.DATA_WIDTH(5), .PARITY_EN(0)) u2 (
        .clock(clock), .reset(reset), .in_data(dat[2][4:0]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .serial_out(so[2]), .busy(bz[2]), .frame_done(fd[2]));
    framed_serializer #(.DATA_WIDTH(32), .LSB_FIRST(0), .BIT_CYCLES(2)) u3 (
        .clock(clock), .reset(reset), .in_data(dat[3]), .in_valid(vld[3]),
        .in_ready(rdy[3]), .serial_out(so[3]), .busy(bz[3]), .frame_done(fd[3]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Expected line waveform of one frame: {last-cycle flag, serial bit} per clock cycle
    function automatic void push_frame(input int k, input logic [31:0] d);
        bit bits [$];
        logic [31:0] m;
        logic [31:0] v;
        m = dw[k] == 32 ? 32'hFFFF_FFFF : (32'h1 << dw[k]) - 32'h1;
        v = d & m;
        bits.push_back(1'b0);
        for (int i = 0; i < dw[k]; i++) bits.push_back(lsb[k] != 0 ? v[i] : v[dw[k]-1-i]);
        if (pen[k] != 0) bits.push_back(^v);
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int j = 0; j < bc[k]; j++)
                q[k].push_back({i == bits.size() - 1 && j == bc[k] - 1, bits[i]});
        acc[k]++;
    endfunction

    // mode 0 random, 1 directed word, 2 idle, 3 held valid with A5/3C alternation, 4 word zero
    task automatic step(input int mode);
        @(negedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            case (mode)
                0: begin vld[k] = 1'($urandom_range(0, 1)); dat[k] = $urandom; end
                1: begin vld[k] = 1'b1; dat[k] = dir[k]; end
                2: begin vld[k] = 1'b0; dat[k] = $urandom; end
                3: begin vld[k] = 1'b1; dat[k] = acc[k][0] ? 32'h3C : 32'hA5; end
                default: begin vld[k] = 1'b1; dat[k] = 32'h0; end
            endcase
            if (vld[k] && rdy[k]) push_frame(k, dat[k]);
        end
    endtask

    // Monitor: one expected sample per cycle per DUT; an empty queue means idle line
    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
            logic [1:0] e;
            bit ef;
            bit em;
            ef = pend[k];
            pend[k] = 1'b0;
            em = q[k].size() == 0;
            e = em ? 2'b01 : q[k].pop_front();
            if (!em) pend[k] = e[1];
            chk("serial_out", k, so[k], e[0]);
            chk("busy", k, bz[k], !em);
            chk("frame_done", k, fd[k], ef);
            chk("in_ready", k, rdy[k], !reset && (em || e[1]));
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            dat[k] = 32'h0;
        end
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        step(1);
        repeat (80) step(2);
        repeat (60) step(3);
        repeat (80) step(2);
        repeat (2000) step(0);
        repeat (80) step(2);
        step(1);
        repeat (3) step(2);
        @(posedge clock);
        #3;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            q[k].delete();
            pend[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_serial_out", k, so[k], 1);
            chk("rst_busy", k, bz[k], 0);
            chk("rst_in_ready", k, rdy[k], 0);
            chk("rst_frame_done", k, fd[k], 0);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        step(4);
        repeat (100) step(2);
        for (int k = 0; k < 4; k++) chk("drained", k, q[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
